// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with prescaled tick, load clamping, terminal-count
// pulse and a time-multiplexed active-low seven-segment scan driver.
module bcd_counter_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 2,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res,
    input  logic                  ena,
    input  logic                  rev,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic [6:0]            hex,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [4*DIGITS-1:0] q_inc;
    logic [4*DIGITS-1:0] q_dec;
    logic [4*DIGITS-1:0] d_clamp;
    logic                all_nine;
    logic                all_zero;
    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       scan_idx;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign tick = (pre_cnt == PRE_LAST);

    // Ripple carry/borrow across digits; all_nine/all_zero flag the wrap cases.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] digit;
        q_inc    = q;
        q_dec    = q;
        d_clamp  = d;
        all_nine = 1'b1;
        all_zero = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        digit    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = q[4*i +: 4];
            if (digit != 4'd9) all_nine = 1'b0;
            if (digit != 4'd0) all_zero = 1'b0;
            if (carry) begin
                if (digit >= 4'd9) begin
                    q_inc[4*i +: 4] = 4'd0;
                end else begin
                    q_inc[4*i +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (d[4*i +: 4] > 4'd9) d_clamp[4*i +: 4] = 4'd9;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
        end else if (res) begin
            q       <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            tc      <= 1'b0;
            if (tick) begin
                if (load) begin
                    q <= d_clamp;
                end else if (ena) begin
                    if (!rev) begin
                        q  <= q_inc;
                        tc <= all_nine;
                    end else begin
                        q  <= q_dec;
                        tc <= all_zero;
                    end
                end
            end
        end
    end

    // Scan outputs follow the index with one cycle of latency; res does not touch the scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            an       <= ~DIGITS'(1);
            hex      <= 7'b1000000;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(DIGITS'(1) << scan_idx);
            hex <= seg7(q[4*scan_idx +: 4]);
        end
    end

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Bench for bcd_counter_scan: two instances (prescale 2 and 1), integer-level reference
// model, vector table, hand sequences for wrap/scan/async reset, and random stimulus.
module tb_bcd_counter_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_res, a_ena, a_rev, a_load;
    logic [15:0] a_d, a_q;
    logic        a_tc;
    logic [6:0]  a_hex;
    logic [3:0]  a_an;
    logic        b_res, b_ena, b_rev, b_load;
    logic [15:0] b_d, b_q;
    logic        b_tc;
    logic [6:0]  b_hex;
    logic [3:0]  b_an;

    bcd_counter_scan #(.DIGITS(4), .PRESCALE(2), .SCAN_DIV(4)) dut_a (
        .clk(clk), .reset(rst_n), .res(a_res), .ena(a_ena), .rev(a_rev), .load(a_load),
        .d(a_d), .q(a_q), .tc(a_tc), .hex(a_hex), .an(a_an));

    bcd_counter_scan #(.DIGITS(4), .PRESCALE(1), .SCAN_DIV(4)) dut_b (
        .clk(clk), .reset(rst_n), .res(b_res), .ena(b_ena), .rev(b_rev), .load(b_load),
        .d(b_d), .q(b_q), .tc(b_tc), .hex(b_hex), .an(b_an));

    typedef struct {
        int         cnt;
        int         pre;
        bit         tc;
        int         st;
        int         idx;
        logic [3:0] an;
        logic [6:0] hex;
    } mdl_t;

    typedef struct {
        bit          res, load, ena, rev;
        logic [15:0] d;
        logic [15:0] exp_q;
        bit          exp_tc;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    mdl_t ma, mb;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] dv);
        int sum, mul, dig;
        sum = 0;
        mul = 1;
        for (int i = 0; i < 4; i++) begin
            dig = int'(dv[4*i +: 4]);
            if (dig > 9) dig = 9;
            sum += dig * mul;
            mul *= 10;
        end
        return sum;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.cnt = 0; m.pre = 0; m.tc = 0; m.st = 0; m.idx = 0;
        m.an = 4'b1110; m.hex = 7'b1000000;
        return m;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit res, input bit load, input bit ena,
                                  input bit rev, input logic [15:0] dv, input int p, input int s);
        mdl_t n;
        int   dig;
        bit   tick;
        logic [3:0] one;
        n    = m;
        one  = 4'b0001;
        tick = (m.pre == p - 1);
        dig  = m.cnt;
        for (int i = 0; i < m.idx; i++) dig = dig / 10;
        n.an  = ~(one << m.idx);
        n.hex = seg_of(dig % 10);
        if (m.st == s - 1) begin
            n.st  = 0;
            n.idx = (m.idx + 1) % 4;
        end else begin
            n.st = m.st + 1;
        end
        n.tc = 0;
        if (res) begin
            n.cnt = 0;
            n.pre = 0;
        end else begin
            n.pre = tick ? 0 : m.pre + 1;
            if (tick && load) begin
                n.cnt = clamp_val(dv);
            end else if (tick && ena) begin
                if (!rev) begin
                    n.cnt = (m.cnt + 1) % 10000;
                    n.tc  = (m.cnt == 9999);
                end else begin
                    n.cnt = (m.cnt + 9999) % 10000;
                    n.tc  = (m.cnt == 0);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = step(ma, a_res, a_load, a_ena, a_rev, a_d, 2, 4);
            mb = step(mb, b_res, b_load, b_ena, b_rev, b_d, 1, 4);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_models();
        chk("a_q",   a_q,   to_bcd(ma.cnt));
        chk("a_tc",  a_tc,  ma.tc);
        chk("a_an",  a_an,  ma.an);
        chk("a_hex", a_hex, ma.hex);
        chk("b_q",   b_q,   to_bcd(mb.cnt));
        chk("b_tc",  b_tc,  mb.tc);
        chk("b_an",  b_an,  mb.an);
        chk("b_hex", b_hex, mb.hex);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_models();
    endtask

    vec_t       vt[20];
    logic [3:0] an_seq[4];
    logic [6:0] hex_seq[4];
    bit         tc_seen;
    bit         found;
    logic [3:0] an_prev;
    int         r;

    initial begin
        vt[0]  = '{0,1,0,0,16'h9998,16'h9998,0};
        vt[1]  = '{0,0,1,0,16'h0000,16'h9999,0};
        vt[2]  = '{0,0,1,0,16'h0000,16'h0000,1};
        vt[3]  = '{0,0,0,0,16'h0000,16'h0000,0};
        vt[4]  = '{0,0,1,1,16'h0000,16'h9999,1};
        vt[5]  = '{0,0,0,1,16'h0000,16'h9999,0};
        vt[6]  = '{0,1,0,0,16'hA3F7,16'h9397,0};
        vt[7]  = '{1,1,0,0,16'h1234,16'h0000,0};
        vt[8]  = '{0,1,1,0,16'h0042,16'h0042,0};
        vt[9]  = '{0,0,1,0,16'h0000,16'h0043,0};
        vt[10] = '{0,0,1,1,16'h0000,16'h0042,0};
        vt[11] = '{0,1,0,0,16'h0100,16'h0100,0};
        vt[12] = '{0,0,1,1,16'h0000,16'h0099,0};
        vt[13] = '{0,1,0,0,16'h0999,16'h0999,0};
        vt[14] = '{0,0,1,0,16'h0000,16'h1000,0};
        vt[15] = '{0,0,1,1,16'h0000,16'h0999,0};
        vt[16] = '{1,0,1,0,16'h0000,16'h0000,0};
        vt[17] = '{0,0,1,1,16'h0000,16'h9999,1};
        vt[18] = '{1,0,1,1,16'h0000,16'h0000,0};
        vt[19] = '{0,1,1,1,16'hFFFF,16'h9999,0};
        an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        hex_seq = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

        rst_n = 1'b0;
        {a_res, a_ena, a_rev, a_load} = '0; a_d = '0;
        {b_res, b_ena, b_rev, b_load} = '0; b_d = '0;
        repeat (2) @(negedge clk);
        chk("rst_q",   a_q,   16'h0000);
        chk("rst_tc",  a_tc,  1'b0);
        chk("rst_an",  a_an,  4'b1110);
        chk("rst_hex", a_hex, 7'b1000000);
        chk("rst_b_q", b_q,   16'h0000);
        rst_n = 1'b1;

        // Free count up, prescale 2: 40 edges give 20 ticks
        a_ena = 1'b1;
        tc_seen = 1'b0;
        repeat (40) begin
            cyc();
            tc_seen |= a_tc;
        end
        chk("up40_q",  a_q, 16'h0020);
        chk("up40_tc", tc_seen, 1'b0);
        a_ena = 1'b0;

        for (int i = 0; i < 20; i++) begin
            b_res = vt[i].res; b_load = vt[i].load; b_ena = vt[i].ena;
            b_rev = vt[i].rev; b_d = vt[i].d;
            cyc();
            chk($sformatf("vec%0d_q", i),  b_q,  vt[i].exp_q);
            chk($sformatf("vec%0d_tc", i), b_tc, vt[i].exp_tc);
        end

        // Scan sequence with 1234 held
        b_res = 0; b_load = 1; b_ena = 0; b_d = 16'h1234;
        cyc();
        b_load = 0;
        repeat (5) cyc();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            an_prev = b_an;
            cyc();
            if (an_prev != 4'b1110 && b_an == 4'b1110) found = 1'b1;
        end
        chk("scan_align", found, 1'b1);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan%0d_an", s),  b_an,  an_seq[s]);
                chk($sformatf("scan%0d_hex", s), b_hex, hex_seq[s]);
                cyc();
            end
        end

        // Async reset mid-count at 0057
        a_res = 0; a_load = 0; a_rev = 0; a_ena = 1;
        for (int i = 0; i < 400 && a_q != 16'h0057; i++) cyc();
        chk("wait_57", a_q, 16'h0057);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q",   a_q,   16'h0000);
        chk("arst_tc",  a_tc,  1'b0);
        chk("arst_an",  a_an,  4'b1110);
        chk("arst_hex", a_hex, 7'b1000000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("restart0", a_q, 16'h0000);
        cyc();
        chk("restart1", a_q, 16'h0001);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            a_res  = ($urandom_range(31) == 0);
            a_load = ($urandom_range(7) == 0);
            a_ena  = ($urandom_range(3) != 0);
            a_rev  = 1'($urandom);
            r = $urandom_range(3);
            a_d    = (r == 0) ? 16'h9999 : (r == 1) ? 16'h0000 : 16'($urandom);
            b_res  = ($urandom_range(31) == 0);
            b_load = ($urandom_range(7) == 0);
            b_ena  = ($urandom_range(3) != 0);
            b_rev  = 1'($urandom);
            r = $urandom_range(3);
            b_d    = (r == 0) ? 16'h9998 : (r == 1) ? 16'h0001 : 16'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
